// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds pc/instr, issues imem reads with a ready handshake,
// and buffers one early fetch-next request while a read is outstanding.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PcInc,
    input  logic        PcSel,
    input  logic [31:0] AluOut,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        pend;
    logic        pend_sel;
    logic [31:0] pend_alu;

    logic        use_sel;
    logic [31:0] use_alu;
    logic        go;
    logic        done;
    logic        bad;
    logic [31:0] tgt;

    // A buffered request takes precedence over a live PcInc in HOLD.
    always_comb begin
        use_sel = pend ? pend_sel : PcSel;
        use_alu = pend ? pend_alu : AluOut;
        go      = (state == HOLD) && (pend || PcInc);
        done    = (state == FETCH) && imem_req && imem_ready;
        bad     = use_sel && (use_alu[1:0] != 2'b00);
        tgt     = use_sel ? use_alu : pc + 32'd4;
        state_d = state;
        unique case (state)
            BOOT:  state_d = FETCH;
            FETCH: if (done) state_d = HOLD;
            HOLD:  if (go) state_d = bad ? HALT : FETCH;
            HALT:  state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            imem_addr   <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
            pend        <= 1'b0;
            pend_sel    <= 1'b0;
            pend_alu    <= 32'd0;
        end else begin
            unique case (state)
                BOOT: begin
                    imem_req  <= 1'b1;
                    imem_addr <= RESET_PC;
                end
                FETCH: begin
                    // Only the first early request is kept.
                    if (PcInc && !pend) begin
                        pend     <= 1'b1;
                        pend_sel <= PcSel;
                        pend_alu <= AluOut;
                    end
                    if (done) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                    end
                end
                HOLD: begin
                    if (go) begin
                        pend <= 1'b0;
                        if (bad) begin
                            misaligned <= 1'b1;
                        end else begin
                            pc          <= tgt;
                            imem_addr   <= tgt;
                            imem_req    <= 1'b1;
                            instr_valid <= 1'b0;
                            instr       <= NOP_INSTR;
                        end
                    end
                end
                HALT: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, wait states, branch, wrap,
// pending request, misalignment halt and reset during a handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PcInc;
    logic        PcSel;
    logic [31:0] AluOut;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misaligned;

    int total = 0;
    int bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk(clk), .rst(rst), .PcInc(PcInc), .PcSel(PcSel), .AluOut(AluOut),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .pc(pc), .instr(instr),
        .instr_valid(instr_valid), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle PcInc pulse.
    task automatic inc(input logic sel, input logic [31:0] alu);
        PcInc = 1'b1; PcSel = sel; AluOut = alu;
        step();
        PcInc = 1'b0;
    endtask

    // Complete the outstanding read with the given word.
    task automatic serve(input logic [31:0] data);
        imem_ready = 1'b1; imem_rdata = data;
        step();
        imem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; PcInc = 1'b0; PcSel = 1'b0; AluOut = 32'd0;
        imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);

        rst = 1'b0;
        step();
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, 32'd0);
        chk("boot_valid", {31'd0, instr_valid}, 32'd0);
        step();
        imem_ready = 1'b0;
        chk("boot_instr", instr, 32'h0050_0093);
        chk("boot_valid1", {31'd0, instr_valid}, 32'd1);
        chk("boot_pc", pc, 32'd0);
        chk("boot_req0", {31'd0, imem_req}, 32'd0);
        step();
        chk("hold_instr", instr, 32'h0050_0093);
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);

        inc(1'b1, 32'h0000_0100);
        chk("br100_pc", pc, 32'h100);
        chk("br100_addr", imem_addr, 32'h100);
        chk("br100_instr", instr, NOP);
        serve(32'hAAAA_0001);
        chk("br100_done", instr, 32'hAAAA_0001);

        inc(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("ws_addr", imem_addr, 32'h104);
            chk("ws_req", {31'd0, imem_req}, 32'd1);
            chk("ws_valid", {31'd0, instr_valid}, 32'd0);
            if (i < 3) step();
        end
        serve(32'h1111_1111);
        chk("ws_pc", pc, 32'h104);
        chk("ws_instr", instr, 32'h1111_1111);
        chk("ws_valid1", {31'd0, instr_valid}, 32'd1);

        inc(1'b1, 32'h0000_0040);
        chk("br40_pc", pc, 32'h40);
        serve(32'h0000_0001);
        inc(1'b1, 32'hFFFF_FFFC);
        serve(32'h0000_0002);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        inc(1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        serve(32'h2222_2222);
        chk("wrap_instr", instr, 32'h2222_2222);

        inc(1'b1, 32'h0000_0100);
        inc(1'b1, 32'h0000_0200);
        inc(1'b1, 32'h0000_0300);
        chk("pend_addr", imem_addr, 32'h100);
        serve(32'h3333_3333);
        chk("pend_hold_pc", pc, 32'h100);
        chk("pend_hold_instr", instr, 32'h3333_3333);
        step();
        chk("pend_addr2", imem_addr, 32'h200);
        chk("pend_pc2", pc, 32'h200);
        chk("pend_req2", {31'd0, imem_req}, 32'd1);
        serve(32'h4444_4444);
        chk("pend_instr2", instr, 32'h4444_4444);
        step();
        step();
        chk("pend_noreq", {31'd0, imem_req}, 32'd0);
        chk("pend_pc_kept", pc, 32'h200);
        chk("pend_addr_kept", imem_addr, 32'h200);

        inc(1'b1, 32'h0000_0042);
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_pc", pc, 32'h200);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_instr", instr, 32'h4444_4444);
        chk("mis_valid", {31'd0, instr_valid}, 32'd1);
        inc(1'b0, 32'h0);
        step();
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_pc", pc, 32'h200);

        rst = 1'b1;
        step();
        chk("rst2_mis", {31'd0, misaligned}, 32'd0);
        rst = 1'b0;
        step();
        chk("rst2_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h5555_5555;
        step();
        chk("rmid_valid", {31'd0, instr_valid}, 32'd0);
        chk("rmid_instr", instr, NOP);
        chk("rmid_pc", pc, 32'h0);
        chk("rmid_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0; imem_ready = 1'b0;
        step();
        chk("rmid_boot_req", {31'd0, imem_req}, 32'd1);
        chk("rmid_boot_instr", instr, NOP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
